// File: rtl/qam_cdc_hs_tx_pkg.sv
// Shared types and default sizing for the 64-QAM source-side CDC handshake.
package qam_cdc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RELEASE
  } state_t;

  localparam int DEF_DATA_W      = 6;
  localparam int DEF_TIMEOUT_CYC = 1024;
  localparam int DEF_CNT_W       = 16;

endpackage

// File: rtl/qam_cdc_hs_tx_if.sv
// Upstream valid/ready word stream plus the req/ack/data crossing bundle.
interface qam_cdc_hs_tx_if
  import qam_cdc_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
);

  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  logic              s_ready;
  logic              cdc_req;
  logic [DATA_W-1:0] cdc_data;
  logic              cdc_ack_async;

  // master: upstream producer together with the destination-side acknowledger
  modport master (
    output s_valid, s_data, cdc_ack_async,
    input  s_ready, cdc_req, cdc_data
  );

  // slave: the handshake transmitter
  modport slave (
    input  s_valid, s_data, cdc_ack_async,
    output s_ready, cdc_req, cdc_data
  );

endinterface

// File: rtl/qam_cdc_hs_tx_sync.sv
// 1-bit two-flop synchronizer with synchronous active-low reset.
module cdc_sync_2ff_sr (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/qam_cdc_hs_tx.sv
// Source end of a 4-phase req/ack crossing: latches one word, runs the full
// req/ack cycle, counts completed transfers and flags stalled phases.
module qam_cdc_hs_tx
  import qam_cdc_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  qam_cdc_hs_tx_if.slave   bus,
  output logic             busy,
  output logic [CNT_W-1:0] xfer_count,
  output logic             err_timeout,
  input  logic             err_clr
);

  localparam int PH_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [PH_W-1:0] PH_MAX = PH_W'(TIMEOUT_CYC);

  state_t            state, state_nxt;
  logic              ack_s;
  logic              req_q, req_nxt;
  logic [DATA_W-1:0] data_q, data_nxt;
  logic [PH_W-1:0]   phase_q, phase_nxt;
  logic [CNT_W-1:0]  count_q, count_nxt;
  logic              err_q, err_set;
  logic              ready;

  cdc_sync_2ff_sr u_ack_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (bus.cdc_ack_async),
    .q     (ack_s)
  );

  // A stale acknowledge keeps the source closed until the destination lets go.
  assign ready         = (state == IDLE) && !ack_s;
  assign bus.s_ready   = ready;
  assign bus.cdc_req   = req_q;
  assign bus.cdc_data  = data_q;
  assign busy          = (state != IDLE);
  assign xfer_count    = count_q;
  assign err_timeout   = err_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      req_q   <= 1'b0;
      data_q  <= '0;
      phase_q <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_nxt;
      req_q   <= req_nxt;
      data_q  <= data_nxt;
      phase_q <= phase_nxt;
      count_q <= count_nxt;
      if (err_set) begin
        err_q <= 1'b1;
      end else if (err_clr) begin
        err_q <= 1'b0;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    req_nxt   = req_q;
    data_nxt  = data_q;
    count_nxt = count_q;
    phase_nxt = phase_q;
    if ((state != IDLE) && (phase_q != PH_MAX)) begin
      phase_nxt = phase_q + PH_W'(1);
    end

    case (state)
      IDLE: begin
        if (ready && bus.s_valid) begin
          data_nxt  = bus.s_data;
          req_nxt   = 1'b1;
          state_nxt = REQ;
          phase_nxt = '0;
        end
      end
      REQ: begin
        if (ack_s) begin
          req_nxt   = 1'b0;
          state_nxt = RELEASE;
          phase_nxt = '0;
        end
      end
      RELEASE: begin
        if (!ack_s) begin
          state_nxt = IDLE;
          count_nxt = count_q + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        req_nxt   = 1'b0;
      end
    endcase

    // Flag only on the edge the counter arrives at the limit, so a clear
    // issued while it sits saturated is not immediately overridden.
    err_set = (state != IDLE) && (phase_nxt == PH_MAX) && (phase_q != PH_MAX);
  end

endmodule

// File: tb/tb_qam_cdc_hs_tx.sv
// Scoreboarded bench for the source-side req/ack handshake transmitter.
module tb_qam_cdc_hs_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        err_clr_a, err_clr_b;
  logic        busy_a, busy_b, err_a, err_b;
  logic [15:0] cnt_a;
  logic [3:0]  cnt_b;

  logic ack_man    = 1'b0;
  logic dst_auto   = 1'b0;
  logic ack_auto_a = 1'b0;
  logic ack_b      = 1'b0;
  int   dly_a      = 0;
  int   dly_b      = 0;

  int compared   = 0;
  int mismatched = 0;
  logic [5:0] exp_q[$];

  qam_cdc_hs_tx_if #(.DATA_W(6)) ba ();
  qam_cdc_hs_tx_if #(.DATA_W(6)) bb ();

  assign ba.cdc_ack_async = dst_auto ? ack_auto_a : ack_man;
  assign bb.cdc_ack_async = ack_b;

  qam_cdc_hs_tx #(.DATA_W(6), .TIMEOUT_CYC(16), .CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ba), .busy(busy_a),
    .xfer_count(cnt_a), .err_timeout(err_a), .err_clr(err_clr_a)
  );

  qam_cdc_hs_tx #(.DATA_W(6), .TIMEOUT_CYC(16), .CNT_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bb), .busy(busy_b),
    .xfer_count(cnt_b), .err_timeout(err_b), .err_clr(err_clr_b)
  );

  // Destination responders: mirror req onto ack two edges after they differ.
  always @(posedge clk) begin
    if (!dst_auto || (ba.cdc_req == ack_auto_a)) dly_a <= 0;
    else if (dly_a == 1) begin ack_auto_a <= ba.cdc_req; dly_a <= 0; end
    else dly_a <= dly_a + 1;
  end

  always @(posedge clk) begin
    if (bb.cdc_req == ack_b) dly_b <= 0;
    else if (dly_b == 1) begin ack_b <= bb.cdc_req; dly_b <= 0; end
    else dly_b <= dly_b + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    compared++; if (ba.cdc_req !== 1'b0) begin mismatched++; $display("FAIL rst_req got %b want 0", ba.cdc_req); end
    compared++; if (ba.cdc_data !== 6'h00) begin mismatched++; $display("FAIL rst_data got %h want 00", ba.cdc_data); end
    compared++; if (cnt_a !== 16'd0) begin mismatched++; $display("FAIL rst_count got %0d want 0", cnt_a); end
    compared++; if (err_a !== 1'b0) begin mismatched++; $display("FAIL rst_err got %b want 0", err_a); end
    compared++; if (busy_a !== 1'b0) begin mismatched++; $display("FAIL rst_busy got %b want 0", busy_a); end
    compared++; if (ba.s_ready !== 1'b1) begin mismatched++; $display("FAIL rst_ready got %b want 1", ba.s_ready); end
  endtask

  task automatic test_single();
    logic [5:0] e;
    ba.s_data  = 6'h2A;
    ba.s_valid = 1'b1;
    exp_q.push_back(6'h2A);
    tick();
    ba.s_valid = 1'b0;
    compared++; if (ba.cdc_req !== 1'b1) begin mismatched++; $display("FAIL single_req_rise got %b want 1", ba.cdc_req); end
    compared++; if (ba.s_ready !== 1'b0) begin mismatched++; $display("FAIL single_ready_low got %b want 0", ba.s_ready); end
    compared++;
    if (exp_q.size() == 0) begin mismatched++; $display("FAIL single_data got empty scoreboard want entry"); end
    else begin
      e = exp_q.pop_front();
      if (ba.cdc_data !== e) begin mismatched++; $display("FAIL single_data got %h want %h", ba.cdc_data, e); end
    end
    repeat (4) tick();
    ack_man = 1'b1;
    tick();
    tick();
    compared++; if (ba.cdc_req !== 1'b1) begin mismatched++; $display("FAIL single_req_hold got %b want 1", ba.cdc_req); end
    tick();
    compared++; if (ba.cdc_req !== 1'b0) begin mismatched++; $display("FAIL single_req_fall got %b want 0", ba.cdc_req); end
    compared++; if (ba.cdc_data !== 6'h2A) begin mismatched++; $display("FAIL single_data_hold got %h want 2a", ba.cdc_data); end
    ack_man = 1'b0;
    tick();
    tick();
    compared++; if (busy_a !== 1'b1) begin mismatched++; $display("FAIL single_busy_release got %b want 1", busy_a); end
    compared++; if (cnt_a !== 16'd0) begin mismatched++; $display("FAIL single_count_early got %0d want 0", cnt_a); end
    tick();
    compared++; if (busy_a !== 1'b0) begin mismatched++; $display("FAIL single_idle got %b want 0", busy_a); end
    compared++; if (cnt_a !== 16'd1) begin mismatched++; $display("FAIL single_count got %0d want 1", cnt_a); end
  endtask

  task automatic test_back_to_back();
    int idx = 0;
    int pops = 0;
    int bad_ready = 0;
    int cyc = 0;
    logic prev_req;
    logic accepted;
    logic [5:0] e;
    do_reset();
    dst_auto = 1'b1;
    ba.s_data  = 6'd0;
    ba.s_valid = 1'b1;
    exp_q.push_back(6'd0);
    prev_req = ba.cdc_req;
    while ((idx < 64) && (cyc < 4000)) begin
      accepted = ba.s_valid && ba.s_ready;
      if (ba.s_ready && busy_a) bad_ready++;
      tick();
      cyc++;
      if (accepted) begin
        idx++;
        if (idx < 64) begin
          ba.s_data = 6'(idx);
          exp_q.push_back(6'(idx));
        end else begin
          ba.s_valid = 1'b0;
        end
      end
      if (ba.cdc_req && !prev_req) begin
        pops++;
        compared++;
        if (exp_q.size() == 0) begin mismatched++; $display("FAIL b2b_data got %h want nothing pending", ba.cdc_data); end
        else begin
          e = exp_q.pop_front();
          if (ba.cdc_data !== e) begin mismatched++; $display("FAIL b2b_data got %h want %h", ba.cdc_data, e); end
        end
      end
      prev_req = ba.cdc_req;
    end
    ba.s_valid = 1'b0;
    for (int i = 0; (i < 100) && busy_a; i++) begin
      if (ba.s_ready) bad_ready++;
      tick();
    end
    compared++; if (busy_a !== 1'b0) begin mismatched++; $display("FAIL b2b_drain got busy %b want 0", busy_a); end
    compared++; if (idx !== 64) begin mismatched++; $display("FAIL b2b_accepts got %0d want 64", idx); end
    compared++; if (pops !== 64) begin mismatched++; $display("FAIL b2b_words_seen got %0d want 64", pops); end
    compared++; if (bad_ready !== 0) begin mismatched++; $display("FAIL b2b_ready_outside_idle got %0d want 0", bad_ready); end
    compared++; if (cnt_a !== 16'd64) begin mismatched++; $display("FAIL b2b_count got %0d want 64", cnt_a); end
    dst_auto = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_timeout();
    do_reset();
    ba.s_data  = 6'h11;
    ba.s_valid = 1'b1;
    tick();
    ba.s_valid = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (k == 15) begin
        compared++; if (err_a !== 1'b0) begin mismatched++; $display("FAIL tmo_early got %b want 0", err_a); end
      end
    end
    compared++; if (err_a !== 1'b1) begin mismatched++; $display("FAIL tmo_set got %b want 1", err_a); end
    compared++; if (ba.cdc_req !== 1'b1) begin mismatched++; $display("FAIL tmo_req_held got %b want 1", ba.cdc_req); end
    repeat (5) tick();
    ack_man = 1'b1;
    for (int i = 0; (i < 20) && ba.cdc_req; i++) tick();
    compared++; if (ba.cdc_req !== 1'b0) begin mismatched++; $display("FAIL tmo_req_fall got %b want 0", ba.cdc_req); end
    ack_man = 1'b0;
    for (int i = 0; (i < 20) && busy_a; i++) tick();
    compared++; if (cnt_a !== 16'd1) begin mismatched++; $display("FAIL tmo_complete got %0d want 1", cnt_a); end
    compared++; if (err_a !== 1'b1) begin mismatched++; $display("FAIL tmo_sticky got %b want 1", err_a); end
    err_clr_a = 1'b1;
    tick();
    err_clr_a = 1'b0;
    compared++; if (err_a !== 1'b0) begin mismatched++; $display("FAIL tmo_clear got %b want 0", err_a); end
  endtask

  task automatic test_collision();
    do_reset();
    ba.s_data  = 6'h15;
    ba.s_valid = 1'b1;
    tick();
    ba.s_valid = 1'b0;
    repeat (15) tick();
    compared++; if (err_a !== 1'b0) begin mismatched++; $display("FAIL coll_pre got %b want 0", err_a); end
    err_clr_a = 1'b1;
    tick();
    err_clr_a = 1'b0;
    compared++; if (err_a !== 1'b1) begin mismatched++; $display("FAIL coll_set_wins got %b want 1", err_a); end
  endtask

  task automatic test_reset_mid_req();
    do_reset();
    dst_auto = 1'b1;
    ba.s_data  = 6'h07;
    ba.s_valid = 1'b1;
    tick();
    ba.s_valid = 1'b0;
    for (int i = 0; (i < 50) && (cnt_a != 16'd1 || busy_a); i++) tick();
    compared++; if (cnt_a !== 16'd1) begin mismatched++; $display("FAIL mid_pre_count got %0d want 1", cnt_a); end
    dst_auto = 1'b0;
    ba.s_data  = 6'h3C;
    ba.s_valid = 1'b1;
    tick();
    ba.s_valid = 1'b0;
    ack_man = 1'b1;
    tick();
    tick();
    compared++; if (ba.cdc_req !== 1'b1) begin mismatched++; $display("FAIL mid_in_req got %b want 1", ba.cdc_req); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    compared++; if (ba.cdc_req !== 1'b0) begin mismatched++; $display("FAIL mid_req_drop got %b want 0", ba.cdc_req); end
    compared++; if (cnt_a !== 16'd0) begin mismatched++; $display("FAIL mid_count got %0d want 0", cnt_a); end
    compared++; if (ba.cdc_data !== 6'h00) begin mismatched++; $display("FAIL mid_data got %h want 00", ba.cdc_data); end
    tick();
    tick();
    compared++; if (ba.s_ready !== 1'b0) begin mismatched++; $display("FAIL mid_stale_ack_a got %b want 0", ba.s_ready); end
    tick();
    compared++; if (ba.s_ready !== 1'b0) begin mismatched++; $display("FAIL mid_stale_ack_b got %b want 0", ba.s_ready); end
    ack_man = 1'b0;
    tick();
    compared++; if (ba.s_ready !== 1'b0) begin mismatched++; $display("FAIL mid_ack_fall_1 got %b want 0", ba.s_ready); end
    tick();
    compared++; if (ba.s_ready !== 1'b1) begin mismatched++; $display("FAIL mid_ack_fall_2 got %b want 1", ba.s_ready); end
  endtask

  task automatic test_wrap();
    int n = 0;
    do_reset();
    bb.s_data  = 6'd0;
    bb.s_valid = 1'b1;
    for (int c = 0; (c < 3000) && (n < 17); c++) begin
      if (bb.s_ready) begin
        tick();
        n++;
        bb.s_data = 6'(n);
      end else begin
        tick();
      end
    end
    bb.s_valid = 1'b0;
    for (int i = 0; (i < 50) && busy_b; i++) tick();
    compared++; if (n !== 17) begin mismatched++; $display("FAIL wrap_accepts got %0d want 17", n); end
    compared++; if (cnt_b !== 4'd1) begin mismatched++; $display("FAIL wrap_count got %0d want 1", cnt_b); end
  endtask

  initial begin
    rst_n      = 1'b0;
    err_clr_a  = 1'b0;
    err_clr_b  = 1'b0;
    ba.s_valid = 1'b0;
    ba.s_data  = '0;
    bb.s_valid = 1'b0;
    bb.s_data  = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_timeout();
    test_collision();
    test_reset_mid_req();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got no finish want finish before 1ms");
    $fatal(1, "watchdog expired");
  end

endmodule
